// File: rtl/mmio_timer_array_if.sv
// Device-bus control signals for the timer bank: address, write strobe, interrupt
// and an observable read-drive enable for the shared tri-state data bus.
interface mmio_timer_array_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] abus;
    logic             we;
    logic             intr;
    logic             dbus_oe;

    modport master (output abus, we, input intr, dbus_oe);
    modport slave  (input abus, we, output intr, dbus_oe);
endinterface

// File: rtl/mmio_timer_array.sv
// Memory-mapped bank of NUM_CH programmable timers sharing one prescaler.
// Each channel: CNT/LIM/CTL/STATUS at +0/+4/+8/+C, sticky READY/OVERRUN, ORed interrupt.
module mmio_timer_ch #(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             wr_cnt_i,
    input  logic             wr_lim_i,
    input  logic             wr_ctl_i,
    input  logic             wr_sts_i,
    input  logic [DBITS-1:0] wdata_i,
    output logic [DBITS-1:0] cnt_o,
    output logic [DBITS-1:0] lim_o,
    output logic [2:0]       ctl_o,
    output logic [1:0]       sts_o
);
    logic [DBITS-1:0] cnt_q, cnt_d, lim_q, lim_d;
    logic [2:0]       ctl_q, ctl_d;
    logic [1:0]       sts_q, sts_d;
    logic             expire;

    always_comb begin
        cnt_d  = cnt_q;
        lim_d  = lim_q;
        ctl_d  = ctl_q;
        sts_d  = sts_q;
        expire = 1'b0;
        if (tick_i && ctl_q[0]) begin
            // LIM==0 is a free-running wrap counter that never expires
            if (lim_q != '0 && cnt_q == lim_q - DBITS'(1)) begin
                cnt_d  = '0;
                expire = 1'b1;
                if (!ctl_q[1]) ctl_d[0] = 1'b0;
            end else begin
                cnt_d = cnt_q + DBITS'(1);
            end
        end
        if (wr_sts_i) sts_d = sts_q & wdata_i[1:0];
        // expiry outranks a same-edge software clear
        if (expire)   sts_d = sts_d | {sts_q[0], 1'b1};
        if (wr_cnt_i) cnt_d = wdata_i;
        if (wr_lim_i) lim_d = wdata_i;
        if (wr_ctl_i) ctl_d = wdata_i[2:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            lim_q <= '0;
            ctl_q <= '0;
            sts_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
            ctl_q <= ctl_d;
            sts_q <= sts_d;
        end
    end

    assign cnt_o = cnt_q;
    assign lim_o = lim_q;
    assign ctl_o = ctl_q;
    assign sts_o = sts_q;
endmodule

module mmio_timer_array #(
    parameter int               DBITS     = 32,
    parameter int               NUM_CH    = 4,
    parameter logic [DBITS-1:0] BASE_ADDR = 32'hF000_0100,
    parameter int               PRESCALE  = 50000
) (
    input  logic             clk,
    input  logic             reset,
    inout  tri   [DBITS-1:0] dbus,
    mmio_timer_array_if.slave bus
);
    localparam int               PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int               CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DBITS-1:0] SPAN = DBITS'(16 * NUM_CH);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick    = (presc_q == PW'(PRESCALE - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    // Offset below BASE wraps to a huge value, so one unsigned compare bounds both ends
    logic [DBITS-1:0] off;
    logic             hit, wr;
    logic [CW-1:0]    sel;
    logic [1:0]       ridx;

    assign off  = bus.abus - BASE_ADDR;
    assign hit  = (off < SPAN) && (off[1:0] == 2'b00);
    assign sel  = off[4 +: CW];
    assign ridx = off[3:2];
    assign wr   = hit && bus.we;

    logic [NUM_CH-1:0][DBITS-1:0] cnt_w, lim_w;
    logic [NUM_CH-1:0][2:0]       ctl_w;
    logic [NUM_CH-1:0][1:0]       sts_w;
    logic [NUM_CH-1:0]            irq_w;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic wsel;
        assign wsel = wr && (sel == CW'(c));

        mmio_timer_ch #(.DBITS(DBITS)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick_i   (tick),
            .wr_cnt_i (wsel && ridx == 2'd0),
            .wr_lim_i (wsel && ridx == 2'd1),
            .wr_ctl_i (wsel && ridx == 2'd2),
            .wr_sts_i (wsel && ridx == 2'd3),
            .wdata_i  (dbus),
            .cnt_o    (cnt_w[c]),
            .lim_o    (lim_w[c]),
            .ctl_o    (ctl_w[c]),
            .sts_o    (sts_w[c])
        );

        assign irq_w[c] = sts_w[c][0] & ctl_w[c][2];
    end

    logic [DBITS-1:0] rdata;
    logic             oe;

    always_comb begin
        rdata = '0;
        case (ridx)
            2'd0:    rdata = cnt_w[sel];
            2'd1:    rdata = lim_w[sel];
            2'd2:    rdata = {{(DBITS-3){1'b0}}, ctl_w[sel]};
            default: rdata = {{(DBITS-2){1'b0}}, sts_w[sel]};
        endcase
    end

    assign oe          = hit && !bus.we;
    assign dbus        = oe ? rdata : 'z;
    assign bus.dbus_oe = oe;
    assign bus.intr    = |irq_w;
endmodule

// File: doc/mmio_timer_array.md
# mmio_timer_array

Memory-mapped bank of NUM_CH independent programmable timers on the processor's abus/dbus/we device bus, alongside the key, switch, LED and HEX devices. It generalises the single fixed timer device in three ways: parametrised channel count and width, a shared prescaler, and per-channel one-shot/periodic mode. Each channel has its own sticky status and interrupt enable, and the channels are ORed onto one interrupt line. Software polls or takes the interrupt, then clears status with a bus write.

## Interface
- DBITS, 32, data/address width
- NUM_CH, 4, number of timer channels (1..16)
- BASE_ADDR, 32'hF0000100, byte address of channel 0; channel c occupies BASE_ADDR + 16*c
- PRESCALE, 50000, clk cycles per timer tick (>= 1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- abus  in  DBITS  byte address from the pipeline ALU result
- dbus  inout  DBITS  shared tri-state data bus
- we  in  1  bus write strobe (store in the memory stage)
- intr  out  1  OR over channels of STATUS.READY & CTL.IE

## Operation
- Per-channel registers at offset from the channel base; other offsets are unmapped:
  - +0x0 CNT: current count, read/write.
  - +0x4 LIM: terminal value, read/write.
  - +0x8 CTL: bit0 EN, bit1 MODE (0 = one-shot, 1 = periodic), bit2 IE. Upper bits read 0.
  - +0xC STATUS: bit0 READY, bit1 OVERRUN. Upper bits read 0.
- A write to STATUS clears each bit whose written value is 0; writing 1 leaves the bit unchanged.
- Address decode: a full DBITS compare; abus[1:0] must be 00. No aliasing outside BASE_ADDR .. BASE_ADDR+16*NUM_CH-1.
- Read: when !we and abus hits a mapped register, dbus is driven with that register. Otherwise dbus is 'z'. The device never drives dbus while we=1.
- Prescaler: a global counter runs 0..PRESCALE-1 continuously from reset. tick = (prescaler == PRESCALE-1). With PRESCALE=1, tick is high every cycle.
- Channel on a tick with EN=1:
  - LIM == 0: CNT increments, wraps from 2^DBITS-1 to 0, and never sets READY.
  - CNT == LIM-1: CNT becomes 0 and READY is set. If READY was already 1, OVERRUN is also set. In one-shot mode EN is cleared.
  - Otherwise CNT increments by 1.
- A channel with EN=0 holds CNT.
- Simultaneous events, same edge:
  - Bus write to CNT or CTL wins over tick update of that register.
  - Expiry setting READY/OVERRUN wins over a bus clear of those bits.
  - Write to LIM takes effect for the comparison on the next tick.
- Reset (asynchronous, any time):
  - Outputs and registers: every CNT, LIM, CTL and STATUS = 0; prescaler = 0; intr = 0; dbus = 'z'.
  - In-progress counts are discarded.

## Timing
- All register state updates on the rising clk edge; reset acts immediately on assertion.
- Write latency: data on dbus with we=1 at edge N is readable from cycle N+1.
- Read latency: combinational from the registered state, so data is valid in the same cycle abus is presented (memory-stage load).
- intr is combinational from registered READY/IE only. It rises the cycle after the expiring edge and falls the cycle after READY is cleared or IE is written 0.
- Period: a periodic channel with LIM=L sets READY every L*PRESCALE cycles.

## Test plan
- One-shot: PRESCALE=4, ch0 LIM=3, CTL=0b101 -> READY and intr rise 12 clk after the first tick boundary. EN reads 0 and CNT stays 0 thereafter.
- Periodic with overrun: PRESCALE=1, ch2 LIM=5, CTL=0b011, never cleared -> READY at cycle 5, OVERRUN at cycle 10. STATUS reads 3; intr stays 0 (IE=0). Writing STATUS=0 reads back 0.
- Clear/expire collision: STATUS write 0 on the same edge as an expiry -> READY stays 1. CNT write 7 on a tick edge -> CNT reads 7.
- Decode/tri-state: reads at BASE_ADDR+16*NUM_CH, BASE_ADDR+0x1 and while we=1 -> dbus 'z'. Read of LIM after writing 0xDEADBEEF -> 0xDEADBEEF.
- Reset mid-count: assert reset with ch1 at CNT=9 and intr=1 -> intr=0 immediately. After release all registers read 0 and no ticks occur until EN is written.
- LIM=0 wrap: CNT preset to 0xFFFFFFFF, EN=1, PRESCALE=1 -> CNT=0 next cycle and READY stays 0.
